// File: rtl/seg7_capture.sv
// seg7_capture: recovers hex nibbles from a debounced 7-segment bus into a valid/ready holding register
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       clr_ovr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_nibble,
  output logic       out_err,
  output logic       ovr
);
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t state;
  logic [6:0] seg_q, last_emit;
  logic [CNT_W-1:0] cnt;
  logic [3:0] nib;
  logic err, same, settle, emit, load, drop;
  always_comb begin
    nib = 4'h0;
    err = 1'b0;
    case (seg_q)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: err = 1'b1;
    endcase
  end
  assign same   = seg == seg_q;
  assign settle = state == SETTLE && same && cnt == CNT_W'(STABLE_CYCLES - 1);
  // a blank clears last_emit so the next digit always emits, even if it repeats
  assign emit   = settle && seg_q != 7'h00 && seg_q != last_emit;
  assign load   = emit && (!out_valid || out_ready);
  assign drop   = emit && out_valid && !out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SETTLE;
      seg_q      <= 7'h00;
      last_emit  <= 7'h00;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_nibble <= 4'h0;
      out_err    <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      seg_q <= seg;
      cnt   <= !same ? '0 : cnt == CNT_W'(STABLE_CYCLES) ? cnt : cnt + CNT_W'(1);
      state <= settle ? LOCKED : !same ? SETTLE : state;
      if (settle) last_emit <= seg_q;
      if (load) begin
        out_valid  <= 1'b1;
        out_nibble <= nib;
        out_err    <= err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      ovr <= drop | (ovr & ~clr_ovr);
    end
  end
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed scoreboard bench for seg7_capture
module tb_seg7_capture;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst_n, clr_ovr, out_ready, out_valid, out_err, ovr;
  logic [6:0] seg;
  logic [3:0] out_nibble;
  int total = 0, passed = 0, n;
  logic [4:0] q[$];
  logic [4:0] e;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  seg7_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .clr_ovr(clr_ovr), .out_valid(out_valid),
    .out_ready(out_ready), .out_nibble(out_nibble), .out_err(out_err), .ovr(ovr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!out_valid && cyc < 20);
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      chk("queue_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("event", {out_err, out_nibble}, e);
      end
    end
  initial begin
    rst_n = 0; seg = 7'h00; out_ready = 1; clr_ovr = 0;
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_nibble", out_nibble, 0);
    chk("rst_err", out_err, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1;
    step(7);
    chk("blank_no_event", out_valid, 0);
    seg = 7'h5B; q.push_back(5'h02);
    wait_valid(n);
    chk("latency", n, S + 1);
    step(12);
    chk("held_single", q.size(), 0);
    for (int i = 0; i < 16; i++) begin
      seg = tbl[i]; q.push_back({1'b0, 4'(i)});
      step(7);
      seg = 7'h00;
      step(7);
    end
    chk("sweep_done", q.size(), 0);
    seg = 7'h3F; q.push_back(5'h00);
    step(7);
    seg = 7'h7F;
    step(2);
    seg = 7'h3F;
    step(10);
    chk("glitch_done", q.size(), 0);
    seg = 7'h00;
    step(7);
    seg = 7'h48; q.push_back(5'h10);
    step(7);
    seg = 7'h00;
    step(7);
    chk("err_done", q.size(), 0);
    out_ready = 0;
    seg = 7'h06; q.push_back(5'h01);
    step(7);
    seg = 7'h4F;
    step(7);
    chk("hold_valid", out_valid, 1);
    chk("hold_nibble", out_nibble, 1);
    chk("hold_err", out_err, 0);
    chk("ovr_set", ovr, 1);
    out_ready = 1;
    step(1);
    chk("accept_clear", out_valid, 0);
    chk("ovr_sticky", ovr, 1);
    clr_ovr = 1;
    step(1);
    clr_ovr = 0;
    chk("ovr_cleared", ovr, 0);
    chk("ovr_done", q.size(), 0);
    seg = 7'h00;
    step(7);
    out_ready = 0;
    seg = 7'h6D; q.push_back(5'h05);
    step(7);
    seg = 7'h00;
    step(7);
    seg = 7'h4F;
    step(7);
    chk("pre_rst_ovr", ovr, 1);
    seg = 7'h66;
    step(3);
    chk("pre_rst_cnt", dut.cnt, 2);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_ovr", ovr, 0);
    chk("async_cnt", dut.cnt, 0);
    q.delete();
    step(1);
    rst_n = 1; out_ready = 1; q.push_back(5'h04);
    wait_valid(n);
    chk("reemit_latency", n, S + 1);
    step(3);
    chk("final_queue", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Recovers 4-bit hex values from a 7-segment drive bus. It is the receive-side counterpart of the nibble-to-segment converter feeding the HEX displays.
- Filters segment glitches with a stability counter and decodes each newly settled pattern exactly once.
- Delivers the decoded pattern over a valid/ready output with one holding register.
- Used by self-check logic to read back what the display path is showing.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern counts as settled; legal range 1..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- seg  in  7  segment bus, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g
- clr_ovr  in  1  synchronous clear of ovr
- out_valid  out  1  decoded event available
- out_ready  in  1  consumer accepts the event when out_valid=1 and out_ready=1
- out_nibble  out  4  decoded value; 0 when out_err=1
- out_err  out  1  settled pattern is not in the decode table
- ovr  out  1  sticky: a settled event was dropped because the holding register was full

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - all outputs to 0
  - seg_q to 7'h00, cnt to 0, last_emit to 7'h00
  - FSM to SETTLE
- Input register: seg is registered into seg_q every cycle. All logic works on seg_q.
- Decode table (active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other non-zero pattern decodes as an error.
- Stability counter:
  - If seg != seg_q, cnt is set to 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM states and transitions:
  - SETTLE -> LOCKED when cnt reaches STABLE_CYCLES-1 and seg == seg_q. On that cycle the settled pattern P equals seg_q.
  - LOCKED -> SETTLE on any cycle with seg != seg_q.
  - LOCKED otherwise stays LOCKED; no re-emission while locked.
- Emission, on the SETTLE->LOCKED transition:
  - If P == 7'h00 (blank): nothing is emitted, but last_emit is updated to 7'h00.
  - Else if P == last_emit: suppressed. This covers a glitch that returns to the same digit.
  - Else the event is {nibble, err} and last_emit is set to P.
- Holding register:
  - If out_valid=0, or out_ready=1 on the same cycle: the event loads; out_valid=1 from the next cycle.
  - If out_valid=1 and out_ready=0: the event is dropped, ovr is set to 1, and the held event is unchanged.
  - Latency: a pattern stable from cycle t at the seg pins gives out_valid=1 at cycle t+STABLE_CYCLES+1.
- Handshake rules:
  - out_nibble and out_err stay stable while out_valid=1 and out_ready=0.
  - A handshake with no new event clears out_valid on the next cycle.
  - A handshake coincident with a new event keeps out_valid=1 and presents the new event (back-to-back).
- ovr priority: clr_ovr=1 clears ovr, unless a drop happens on the same cycle; then ovr=1 wins.
- STABLE_CYCLES=1: a pattern settles once seg equals seg_q for a single cycle.
- rst_n asserted mid-settle or mid-handshake discards all state immediately. No event survives reset.

Test Plan:
- Reset, then hold seg=7'h5B with out_ready=1 -> exactly one event 2, err=0; out_valid rises at cycle STABLE_CYCLES+1 after seg is applied; no further events while held.
- Sweep all 16 table patterns, each followed by 7'h00, STABLE_CYCLES=4, out_ready=1 -> nibbles 0..F in order; no err; no events for blanks.
- Apply 7'h3F, then a 2-cycle glitch to 7'h7F, then back to 7'h3F -> single event 0; the glitch produces no event and no error.
- Apply 7'h48 (unlisted) -> event with err=1, nibble=0.
- With out_ready=0, settle 7'h06 then 7'h4F -> held event stays 1; 3 is dropped; ovr=1. Raise out_ready -> event 1 accepted. Pulse clr_ovr -> ovr=0.
- Drive rst_n=0 for 1 cycle while cnt=2 and an event is held -> out_valid, ovr and cnt all 0 immediately. The same pattern re-emits after STABLE_CYCLES+1 cycles.
